fft_config_receiver: RTL
========================

# fft_config_receiver

Responder end of the FFT configuration channel: accepts single-beat direction words on an AXI-Stream slave, buffers one word, and binds it to data frames passing through on a separate AXI-Stream path. Sits directly in front of the transform engine. It takes the place of the core's internal config port, so any config master drives it unchanged. Frames are delimited by a beat counter, tlast is checked against it, and framing errors are reported as single-cycle event pulses.

## Interface
- FFT_LEN, 1024: beats per frame, ≥2.
- CFG_WIDTH, 8: config tdata width. Bit 0 is the direction, 1 = inverse (a master sends 255 for inverse, 0 for forward). Bits [CFG_WIDTH-1:1] are ignored.
- DATA_WIDTH, 32: data tdata width.

Ports:
- aclk, in, 1: clock, all logic on the rising edge.
- areset, in, 1: synchronous, active-high reset.
- config_in, AXIS_intf.Slave: tdata[CFG_WIDTH], tvalid, tready.
- data_in, AXIS_intf.Slave: tdata[DATA_WIDTH], tvalid, tready, tlast.
- data_out, AXIS_intf.Master: tdata[DATA_WIDTH], tvalid, tready, tlast.
- fwd_inv_out, out, 1: direction of the beat currently on data_out, 1 = inverse.
- cfg_applied, out, 1: one-cycle pulse when a buffered config is bound to a frame.
- event_tlast_unexpected, out, 1: one-cycle pulse.
- event_tlast_missing, out, 1: one-cycle pulse.

## Operation
- **Config buffer.** Holds a one-deep register `pend_dir` and a flag `pend_vld`.
  - config_in.tready = !pend_vld, driven from a register with no combinational path from tvalid.
  - A config accept is config_in.tvalid & config_in.tready. On accept: pend_dir <= tdata[0], pend_vld <= 1.
- **Active direction.** `act_dir` is the direction of the current or last frame. After reset it is 0 (forward). It is sticky: a frame with no pending config reuses the previous direction.
- **Data path.** Combinational pass-through:
  - data_out.tdata/tvalid/tlast = data_in.tdata/tvalid/tlast.
  - data_in.tready = data_out.tready.
  - A beat is data_out.tvalid & data_out.tready.
- **Frame state machine.**
  - IDLE (beat counter = 0): the next beat is a frame start.
    - On a beat with pend_vld = 1: act_dir <= pend_dir, pend_vld <= 0, cfg_applied pulses.
    - On any beat: counter <= 1, state becomes FRAME.
  - FRAME: each beat increments the counter.
    - The beat at count FFT_LEN-1 is the last beat of the frame.
    - After it: counter <= 0, state becomes IDLE.
  - Frame boundaries come only from the counter. tlast never ends or restarts a frame.
- **fwd_inv_out.**
  - In IDLE: pend_dir if pend_vld, else act_dir. This way the first beat already carries the new direction.
  - In FRAME: act_dir.
  - It is held stable for the whole frame.
- **tlast checks**, evaluated on beats only:
  - tlast = 1 on a beat with count < FFT_LEN-1: event_tlast_unexpected pulses.
  - tlast = 0 on the beat with count = FFT_LEN-1: event_tlast_missing pulses.
  - In both cases framing continues unchanged.

## Timing
- Reset values: config_in.tready = 1, pend_vld = 0, pend_dir = 0, act_dir = 0, counter = 0, state IDLE, fwd_inv_out = 0, cfg_applied = 0, both events = 0. data_out follows data_in combinationally even during reset.
- Reset mid-frame discards the partial frame and any pending config. The next beat after reset is a frame start with direction forward.
- Config acceptance latency: tready falls the cycle after an accept. It rises the cycle after the pending config is consumed.
- Config accepted on the same cycle as a frame-start beat: pend_vld was 0 in that cycle, so the frame uses the old act_dir. The new config stays pending for the next frame.
- Config arriving during FRAME is accepted immediately if the buffer is empty. It does not affect the current frame.
- A second config while the buffer is full is back-pressured (tready = 0) until the next frame start.
- cfg_applied and the event pulses are registered: each is asserted for exactly the cycle after the causing beat.
- The counter holds on cycles with no beat, whether tvalid = 0 or tready = 0.
- Data path latency is 0 cycles and does not add back-pressure.

## Test plan
- Reset, then one frame of FFT_LEN beats with no config -> fwd_inv_out = 0 on all beats, no cfg_applied, no events.
- Config tdata = 255 while idle, then a frame -> tready is 0 from the next cycle. First beat fwd_inv_out = 1, cfg_applied pulses once, tready returns to 1. A following frame with no config is still 1.
- Config 0 sent mid-frame of an inverse frame -> current frame stays 1 to the end. The next frame is 0 from its first beat.
- Two configs back to back -> the second is stalled with tready = 0 until the next frame start, then accepted and applied to the frame after that.
- FFT_LEN = 8, tlast on beat 3, no tlast on beat 7 -> event_tlast_unexpected after beat 3, event_tlast_missing after beat 7. The next beat still starts a new frame.
- areset asserted mid-frame with a config pending -> the following frame starts at count 0 with fwd_inv_out = 0, no cfg_applied, and tready = 1 after reset.

Source files
------------

// File: rtl/fft_config_receiver_if.sv
// rtl/fft_config_receiver_if.sv - AXI-Stream style handshake bundle used by the FFT config receiver
interface AXIS_intf #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport Master (output tdata, output tvalid, output tlast, input tready);
  modport Slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft_config_receiver.sv
// rtl/fft_config_receiver.sv - binds buffered FFT direction words to counter-delimited data frames
module fft_config_receiver #(
  parameter int FFT_LEN    = 1024,
  parameter int CFG_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic     aclk,
  input  logic     areset,
  AXIS_intf.Slave  config_in,
  AXIS_intf.Slave  data_in,
  AXIS_intf.Master data_out,
  output logic     fwd_inv_out,
  output logic     cfg_applied,
  output logic     event_tlast_unexpected,
  output logic     event_tlast_missing
);

  localparam int CW = $clog2(FFT_LEN);
  localparam logic [CW-1:0] LAST = CW'(FFT_LEN - 1);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          pend_vld;
  logic          pend_dir;
  logic          act_dir;
  logic          cfg_ready;
  logic          beat;
  logic          cfg_acc;
  logic          cfg_unused;

  // Only bit 0 of the config word carries meaning; the rest is accepted and dropped.
  assign cfg_unused = ^{config_in.tdata[CFG_WIDTH-1:1], config_in.tlast};

  // Zero-latency pass-through of the data stream.
  assign data_out.tdata  = data_in.tdata[DATA_WIDTH-1:0];
  assign data_out.tvalid = data_in.tvalid;
  assign data_out.tlast  = data_in.tlast;
  assign data_in.tready  = data_out.tready;

  assign beat             = data_in.tvalid & data_out.tready;
  assign config_in.tready = cfg_ready;
  assign cfg_acc          = config_in.tvalid & cfg_ready;

  // A pending config is visible on the frame-start beat so the whole frame carries one direction.
  assign fwd_inv_out = (state == IDLE && pend_vld) ? pend_dir : act_dir;

  // Config buffer, frame counter and registered event pulses.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state                  <= IDLE;
      count                  <= '0;
      pend_vld               <= 1'b0;
      pend_dir               <= 1'b0;
      act_dir                <= 1'b0;
      cfg_ready              <= 1'b1;
      cfg_applied            <= 1'b0;
      event_tlast_unexpected <= 1'b0;
      event_tlast_missing    <= 1'b0;
    end else begin
      cfg_applied            <= 1'b0;
      event_tlast_unexpected <= 1'b0;
      event_tlast_missing    <= 1'b0;

      // cfg_ready is only high while the buffer is empty, so an accept never
      // coincides with the frame-start consume below.
      if (cfg_acc) begin
        pend_dir  <= config_in.tdata[0];
        pend_vld  <= 1'b1;
        cfg_ready <= 1'b0;
      end

      if (beat) begin
        if (state == IDLE && pend_vld) begin
          act_dir     <= pend_dir;
          pend_vld    <= 1'b0;
          cfg_ready   <= 1'b1;
          cfg_applied <= 1'b1;
        end

        // tlast is only checked against the counter; it never moves frame boundaries.
        if (count == LAST) begin
          event_tlast_missing <= ~data_in.tlast;
          count               <= '0;
          state               <= IDLE;
        end else begin
          event_tlast_unexpected <= data_in.tlast;
          count                  <= count + 1'b1;
          state                  <= FRAME;
        end
      end
    end
  end

endmodule
